shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle sequencer for the 32-bit shift/rotate path. It accepts one shift request at a time over a valid/ready handshake and decomposes the shift amount into power-of-two steps (1, 2, 4, 8, 16). It applies one step per clock through a single shared combinational stage, then returns the result over a second valid/ready handshake. It sits between the ALU issue logic and the writeback mux, provides all five shifter modes (including both rotates) selected at run time, and serialises access to the shift hardware.

## Interface
Parameters:
- `WIDTH`, 32, data width; fixed at 32, since the amount field is 5 bits.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  **synchronous, active-low reset**, sampled on the rising edge of `clock`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  3  0 SLL, 1 ROL, 2 SRL, 3 SRA, 4 ROR; 5–7 pass-through.
- `req_data`  in  32  operand.
- `req_amount`  in  5  shift amount, 0–31.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  32  shifted/rotated result.
- `busy`  out  1  high in RUN or DONE.

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - RUN: one power-of-two step per cycle.
  - DONE: `rsp_valid`=1.
- **Accept:** in IDLE, when `req_valid` && `req_ready`, register `acc`←`req_data`, `op`←`req_op`, `rem`←`req_amount`, step index `k`←0.
  - Next state is DONE if `req_amount`==0 or `op`≥5; otherwise RUN.
- **RUN, each cycle:**
  - If `rem[0]`, then `acc`←stage(`acc`, `op`, 1<<`k`).
  - `rem`←`rem`>>1 and `k`←`k`+1.
  - If the new `rem`==0, go to DONE. Higher zero bits are skipped (early termination).
- **Stage semantics (shift by s):**
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: replicate `acc[31]`.
  - ROL/ROR: circular rotate.
  - Composing the steps yields exactly the single-shot shift by `req_amount`.
- **DONE:**
  - `rsp_data`=`acc`, held stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_ready`=1, go to IDLE.
- `req_ready`=0 in RUN and DONE. Requests are not queued; `req_*` inputs are ignored outside IDLE.
- Pass-through ops (5–7) return `req_data` unchanged.
- **Reset:**
  - While `reset_n`=0 at a clock edge, the state becomes IDLE, and `acc`, `rem`, `k` and `op` are cleared.
  - Any in-flight request is discarded and no response is produced.

## Timing
- **Reset values:** `req_ready`=1 from the first post-reset cycle (state IDLE); `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- **Latency:** for an accept at edge T, the response is at T+1 when amount=0 or the op is pass-through, and at T+2+⌊log2(amount)⌋ otherwise.
  - amount 1 → T+2; amount 4 → T+4; amount 16–31 → T+6.
- **Throughput:** at most one request in flight. The earliest next accept is the cycle after the response handshake; there is no same-cycle DONE→accept bypass.
- **Outputs:** `req_ready`, `rsp_valid` and `busy` are decoded from registered state only. There are no combinational input→output paths.

## Structure
- **Package `shift_pkg`:**
  - Op encoding constants (`OP_SLL`=0 … `OP_ROR`=4).
  - State enum {IDLE, RUN, DONE}.
  - `SHAMT_W`=5.
- **Sub-module `shift_stage`:** purely combinational; inputs `data[31:0]`, `op[2:0]`, `k[2:0]`; output data shifted/rotated by 1<<`k`. It is instantiated once and is the only shifting logic in the block.
- **Top level:** FSM plus the `acc`, `rem`, `k` and `op` registers.

## Test plan
- SLL `0x0000_0001` by 31, accept at T → `rsp_data`=`0x8000_0000`, `rsp_valid` rises at T+6.
- SRA `0x8000_0000` by 4 → `0xF800_0000` at T+4. SRL of the same operand and amount → `0x0800_0000`.
- ROR `0x0000_00F1` by 4 → `0x1000_000F`. ROL `0x8000_0001` by 1 → `0x0000_0003` at T+2.
- Amount 0 (any op), and op 6 with amount 7 → `rsp_data`=`req_data` at T+1.
- Hold `rsp_ready`=0 for 3 cycles in DONE while driving `req_valid`=1 → `rsp_data` stable, `req_ready`=0, no second accept. After the handshake, `req_ready`=1 on the next cycle.
- Assert `reset_n`=0 for one edge mid-RUN (SLL by 31, cycle T+3) → IDLE, `rsp_valid` never asserts for that request. A fresh request then completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: op codes, FSM states, amount width.
package shift_pkg;

  localparam int unsigned SHAMT_W = 5;

  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_ROL  = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_SRA  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  // Codes at or above this value return the operand unchanged.
  localparam logic [2:0] OP_PASS = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/shift_stage.sv
// Single combinational shift/rotate stage: moves data by 1 << k in the direction selected by op.
module shift_stage
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  op,
  input  logic [2:0]  k,
  output logic [31:0] result
);

  logic [5:0]         step;
  logic [63:0]        dbl;
  logic [63:0]        rol_w;
  logic [63:0]        ror_w;
  logic signed [31:0] sra_w;

  assign step  = 6'd1 << k;
  // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
  assign dbl   = {data, data};
  assign rol_w = dbl << step;
  assign ror_w = dbl >> step;
  assign sra_w = $signed(data) >>> step;

  always_comb begin
    result = data;
    unique case (op)
      OP_SLL:  result = data << step;
      OP_ROL:  result = rol_w[63:32];
      OP_SRL:  result = data >> step;
      OP_SRA:  result = sra_w;
      OP_ROR:  result = ror_w[31:0];
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: applies one power-of-two step per clock through one shared
// stage, skipping leading zero amount bits, with valid/ready handshakes on both sides.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [WIDTH-1:0]   req_data,
  input  logic [SHAMT_W-1:0] req_amount,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [2:0]         k_q, k_d;
  logic [WIDTH-1:0]   stage_out;

  shift_stage u_stage (
    .data   (acc_q),
    .op     (op_q),
    .k      (k_q),
    .result (stage_out)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rem_d   = rem_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          acc_d   = req_data;
          op_d    = req_op;
          rem_d   = req_amount;
          k_d     = 3'd0;
          state_d = (req_amount == '0 || req_op >= OP_PASS) ? StDone : StRun;
        end
      end
      StRun: begin
        if (rem_q[0]) begin
          acc_d = stage_out;
        end
        rem_d = rem_q >> 1;
        k_d   = k_q + 3'd1;
        // Stop as soon as no set amount bits remain.
        if ((rem_q >> 1) == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      op_q    <= 3'd0;
      rem_q   <= '0;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign rsp_data  = acc_q;

endmodule
